// File: rtl/micro_pkg.sv
// micro_pkg: shared FSM states, BCD digit limits and the one-hot key encoder
package micro_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_GAP, S_KEY, S_START, S_DONE} state_t;
  localparam logic [3:0] MAX_MIN = 4'd9;
  localparam logic [3:0] MAX_TEN = 4'd5;
  localparam logic [3:0] MAX_ONE = 4'd9;
  function automatic logic [9:0] digit_onehot(input logic [3:0] d);
    return (d > 4'd9) ? 10'd0 : 10'd1 << d;
  endfunction
endpackage

// File: rtl/keypad_sequencer_phase_timer.sv
// phase_timer: loadable down-counter that parks at zero and flags it
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/keypad_sequencer.sv
// keypad_sequencer: replays clear, three timed digit presses and an optional start onto the micro keypad
module keypad_sequencer import micro_pkg::*; #(
  parameter int PRESS_CYCLES = 5,
  parameter int GAP_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req,
  input  logic [3:0] min_bcd,
  input  logic [3:0] ten_bcd,
  input  logic [3:0] one_bcd,
  input  logic       auto_start,
  output logic [9:0] teclado,
  output logic       limpan,
  output logic       comecan,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int MAXPG = PRESS_CYCLES > GAP_CYCLES ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXPG + 1);
  localparam logic [CW-1:0] P_LOAD = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] G_LOAD = CW'(GAP_CYCLES - 1);
  state_t        r_state;
  logic [3:0]    r_min, r_ten, r_one;
  logic          r_as;
  logic [1:0]    r_idx;
  logic [9:0]    r_teclado;
  logic          r_limpan, r_comecan, r_busy, r_done, r_err;
  logic          w_zero, w_legal, w_load;
  logic [CW-1:0] w_load_val;
  logic [3:0]    w_digit;
  assign w_legal = min_bcd <= MAX_MIN && ten_bcd <= MAX_TEN && one_bcd <= MAX_ONE;
  // The timer is reloaded on every phase change; the IDLE and GAP exits start a press
  assign w_load = (r_state == S_IDLE && req && w_legal) ||
                  (r_state inside {S_CLEAR, S_GAP, S_KEY, S_START} && w_zero);
  assign w_load_val = (r_state == S_IDLE || r_state == S_GAP) ? P_LOAD : G_LOAD;
  assign w_digit = r_idx == 2'd0 ? r_min : r_idx == 2'd1 ? r_ten : r_one;
  phase_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_zero (w_zero)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_min     <= '0;
      r_ten     <= '0;
      r_one     <= '0;
      r_as      <= 1'b0;
      r_idx     <= '0;
      r_teclado <= '0;
      r_limpan  <= 1'b1;
      r_comecan <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (req) begin
          if (w_legal) begin
            r_min    <= min_bcd;
            r_ten    <= ten_bcd;
            r_one    <= one_bcd;
            r_as     <= auto_start;
            r_idx    <= '0;
            r_limpan <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_CLEAR;
          end else r_err <= 1'b1;
        end
        S_CLEAR, S_KEY, S_START: if (w_zero) begin
          r_limpan  <= 1'b1;
          r_comecan <= 1'b1;
          r_teclado <= '0;
          r_state   <= S_GAP;
          if (r_state == S_KEY) r_idx <= r_idx + 2'd1;
          // Consuming the start request lets the following GAP fall through to DONE
          if (r_state == S_START) r_as <= 1'b0;
        end
        S_GAP: if (w_zero) begin
          if (r_idx != 2'd3) begin
            r_teclado <= digit_onehot(w_digit);
            r_state   <= S_KEY;
          end else if (r_as) begin
            r_comecan <= 1'b0;
            r_state   <= S_START;
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign teclado = r_teclado;
  assign limpan  = r_limpan;
  assign comecan = r_comecan;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
endmodule

// File: doc/keypad_sequencer.md
# keypad_sequencer

Preset-entry transmitter for the microwave keypad interface. Given a cook time as three BCD digits (minutes, tens of seconds, ones of seconds), it drives the one-hot keypad bus and the active-low clear/start buttons of `micro`. The sequence is the same one an operator produces by hand: clear, three timed key presses with release gaps, then an optional start. It sits beside the physical keypad, feeding `micro` through a priority mux; the mux itself is out of scope. Its main uses are quick-cook presets and bench stimulus.

## Interface
Parameters:
- `PRESS_CYCLES`, default 5: clock cycles a key or button is held active.
- `GAP_CYCLES`, default 8: clock cycles of all-released bus after each press.

Ports:
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req`  in  1  start a sequence; sampled only in IDLE.
- `min_bcd`  in  4  minutes digit; legal range 0–9.
- `ten_bcd`  in  4  tens-of-seconds digit; legal range 0–5.
- `one_bcd`  in  4  ones-of-seconds digit; legal range 0–9.
- `auto_start`  in  1  when 1, append a start press; sampled with `req`.
- `teclado`  out  10  one-hot keypad bus; bit k means digit k; all zeros means no key.
- `limpan`  out  1  clear button, active-low.
- `comecan`  out  1  start button, active-low.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `err`  out  1  one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, CLEAR, GAP, KEY, START, DONE.
- Reset and IDLE outputs:
  - `teclado`=0, `limpan`=1, `comecan`=1.
  - `busy`=0, `done`=0, `err`=0.
- Request handling in IDLE, on `req`=1:
  - Validate the digits. If `min_bcd`>9, `ten_bcd`>5 or `one_bcd`>9, pulse `err` and stay in IDLE.
  - If the digits are legal, latch all three digits and `auto_start` into internal registers, then go to CLEAR.
- Sequence order:
  - CLEAR: `limpan`=0 for PRESS_CYCLES.
  - GAP.
  - KEY with the minutes digit, then GAP.
  - KEY with the tens digit, then GAP.
  - KEY with the ones digit, then GAP.
  - If the latched `auto_start`=1: START (`comecan`=0 for PRESS_CYCLES), then GAP.
  - DONE.
- Each KEY state drives `teclado` = 1<<digit for PRESS_CYCLES. Leading zeros are sent; no suppression.
- DONE lasts one cycle with `done`=1, then returns to IDLE.
- A 2-bit digit index selects the latched digit. One down-counter, sized $clog2(max(PRESS,GAP)+1), times every phase.
- Changes on `req` or the digit inputs while busy are ignored. The latched values are used.
- Exactly one of {`teclado` nonzero, `limpan`=0, `comecan`=0} may be active in any cycle. Never more than one.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Cycle 0 is the edge that samples `req`. From cycle 1, `busy`=1 and `limpan`=0.
- `busy` is 1 from cycle 1 through the last GAP cycle inclusive.
- Total length with defaults P=5, G=8:
  - Without start: 4·(P+G)=52 cycles; `done` high in cycle 53, `busy` low from cycle 53.
  - With start: 5·(P+G)=65 cycles; `done` high in cycle 66.
- `err` is high in cycle 1 for a rejected request; `busy` stays 0.
- Back-to-back: `req` held high through DONE is sampled in the next IDLE cycle. The minimum spacing is one IDLE cycle.
- Asynchronous `resetn` low mid-sequence: all outputs take their reset values immediately, with no partial press completed. The first accepted `req` after release restarts from CLEAR.

## Structure
- Shared package `micro_pkg` holds:
  - the state enum;
  - digit limits MAX_MIN=9, MAX_TEN=5, MAX_ONE=9;
  - function `digit_onehot(4b)→10b`.
- The mux in front of `micro` reuses `digit_onehot`.
- Natural sub-module: `phase_timer` (load value, decrement, `zero` flag). Everything else lives in the FSM module.

## Test plan
- Reset, then `req` with 3/2/7, `auto_start`=0 → in order:
  - `limpan`=0 for 5 cycles;
  - `teclado`=0000001000 for 5 cycles;
  - `teclado`=0000000100 for 5 cycles;
  - `teclado`=0010000000 for 5 cycles;
  - 8-cycle zero gaps between presses;
  - `done` at cycle 53; `comecan` stays 1 throughout.
- `req` with 0/0/9, `auto_start`=1 → `teclado`=0000000001 twice, then 1000000000; `comecan`=0 for cycles 53–57; `done` at cycle 66.
- `req` with `ten_bcd`=6 → `err` high for cycle 1 only; `busy`=0; all bus outputs stay idle.
- Toggle `req` and the digit inputs mid-sequence → the bus still shows the originally latched digits; no second sequence starts.
- Assert `resetn` low during the tens KEY phase → `teclado`=0, `busy`=0 within the same cycle. A new `req` with 1/0/0 then completes normally.
- Throughout all runs, assert a one-hot-or-zero `teclado` and mutual exclusion of the three actuators.
